complete_bus_arbiter: RTL and testbench



---
 rtl/complete_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_complete_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/complete_bus_arbiter.sv
// rtl/complete_bus_arbiter.sv - four FU result FIFOs arbitrated round-robin onto two complete buses
// Optional macro COMPLETE_BUS_ARB_BYPASS_EN: an empty FU's live input competes in the same cycle.
module complete_bus_arbiter #(
   parameter int TAG_W = 6,
   parameter int ROB_W = 5
) (
   input  logic                  CLK,
   input  logic                  RST,
   output logic                  DUT_error,
   input  logic [3:0]            fu_valid,
   output logic [3:0]            fu_ready,
   input  logic [3:0][TAG_W-1:0] fu_dest_phys_reg_tag,
   input  logic [3:0][31:0]      fu_data,
   input  logic [3:0][ROB_W-1:0] fu_rob_index,
   output logic                  complete_bus_0_valid,
   output logic [TAG_W-1:0]      complete_bus_0_dest_phys_reg_tag,
   output logic [31:0]           complete_bus_0_data,
   output logic [ROB_W-1:0]      complete_bus_0_rob_index,
   output logic                  complete_bus_1_valid,
   output logic [TAG_W-1:0]      complete_bus_1_dest_phys_reg_tag,
   output logic [31:0]           complete_bus_1_data,
   output logic [ROB_W-1:0]      complete_bus_1_rob_index
);

   logic [TAG_W-1:0] q_tag  [4][2];
   logic [31:0]      q_data [4][2];
   logic [ROB_W-1:0] q_rob  [4][2];
   logic [1:0]       cnt    [4];
   logic [3:0]       rd_ptr, wr_ptr;
   logic [1:0]       rr_ptr;

   logic [3:0]       empty, full, cand, grant, push, pop;
   logic [TAG_W-1:0] src_tag  [4];
   logic [31:0]      src_data [4];
   logic [ROB_W-1:0] src_rob  [4];
   logic             g0_vld, g1_vld;
   logic [1:0]       g0_idx, g1_idx;
   logic             next_DUT_error;

   assign fu_ready = ~full;

   // Arbitration source per FU: FIFO head, or the live input when bypass is enabled and the FIFO is empty.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         empty[i] = (cnt[i] == 2'd0);
         full[i]  = (cnt[i] == 2'd2);
`ifdef COMPLETE_BUS_ARB_BYPASS_EN
         if (empty[i]) begin
            src_tag[i]  = fu_dest_phys_reg_tag[i];
            src_data[i] = fu_data[i];
            src_rob[i]  = fu_rob_index[i];
            cand[i]     = fu_valid[i];
         end else begin
            src_tag[i]  = q_tag[i][rd_ptr[i]];
            src_data[i] = q_data[i][rd_ptr[i]];
            src_rob[i]  = q_rob[i][rd_ptr[i]];
            cand[i]     = 1'b1;
         end
`else
         src_tag[i]  = q_tag[i][rd_ptr[i]];
         src_data[i] = q_data[i][rd_ptr[i]];
         src_rob[i]  = q_rob[i][rd_ptr[i]];
         cand[i]     = ~empty[i];
`endif
      end
   end

   always_comb begin
      logic [1:0] idx;
      g0_vld = 1'b0;
      g1_vld = 1'b0;
      g0_idx = 2'd0;
      g1_idx = 2'd0;
      idx    = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr + 2'(k);
         if (cand[idx]) begin
            if (!g0_vld) begin
               g0_vld = 1'b1;
               g0_idx = idx;
            end else if (!g1_vld) begin
               g1_vld = 1'b1;
               g1_idx = idx;
            end
         end
      end
   end

   // A bypass-granted FU (empty FIFO) consumes its input directly, so it is not also written.
   always_comb begin
      grant = '0;
      if (g0_vld) grant[g0_idx] = 1'b1;
      if (g1_vld) grant[g1_idx] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pop[i]  = grant[i] & ~empty[i];
         push[i] = fu_valid[i] & ~full[i] & ~(grant[i] & empty[i]);
      end
      next_DUT_error = (g0_vld && (src_tag[g0_idx] == '0)) ||
                       (g1_vld && ((src_tag[g1_idx] == '0) || (src_tag[g1_idx] == src_tag[g0_idx])));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= 2'd0;
            for (int j = 0; j < 2; j++) begin
               q_tag[i][j]  <= '0;
               q_data[i][j] <= '0;
               q_rob[i][j]  <= '0;
            end
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
               q_tag[i][wr_ptr[i]]  <= fu_dest_phys_reg_tag[i];
               q_data[i][wr_ptr[i]] <= fu_data[i];
               q_rob[i][wr_ptr[i]]  <= fu_rob_index[i];
               wr_ptr[i]            <= ~wr_ptr[i];
            end
            if (pop[i]) rd_ptr[i] <= ~rd_ptr[i];
            if (push[i] && !pop[i]) cnt[i] <= cnt[i] + 2'd1;
            else if (!push[i] && pop[i]) cnt[i] <= cnt[i] - 2'd1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rr_ptr                           <= 2'd0;
         DUT_error                        <= 1'b0;
         complete_bus_0_valid             <= 1'b0;
         complete_bus_0_dest_phys_reg_tag <= '0;
         complete_bus_0_data              <= '0;
         complete_bus_0_rob_index         <= '0;
         complete_bus_1_valid             <= 1'b0;
         complete_bus_1_dest_phys_reg_tag <= '0;
         complete_bus_1_data              <= '0;
         complete_bus_1_rob_index         <= '0;
      end else begin
         DUT_error            <= next_DUT_error;
         complete_bus_0_valid <= g0_vld;
         complete_bus_1_valid <= g1_vld;
         if (g0_vld) begin
            complete_bus_0_dest_phys_reg_tag <= src_tag[g0_idx];
            complete_bus_0_data              <= src_data[g0_idx];
            complete_bus_0_rob_index         <= src_rob[g0_idx];
         end
         if (g1_vld) begin
            complete_bus_1_dest_phys_reg_tag <= src_tag[g1_idx];
            complete_bus_1_data              <= src_data[g1_idx];
            complete_bus_1_rob_index         <= src_rob[g1_idx];
         end
         if (g1_vld) rr_ptr <= g1_idx + 2'd1;
         else if (g0_vld) rr_ptr <= g0_idx + 2'd1;
      end
   end

endmodule

// File: tb/tb_complete_bus_arbiter.sv
// tb/tb_complete_bus_arbiter.sv - directed self-checking bench for complete_bus_arbiter
module tb_complete_bus_arbiter;
   localparam int TAG_W = 6;
   localparam int ROB_W = 5;
`ifdef COMPLETE_BUS_ARB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic                  CLK = 1'b0;
   logic                  RST;
   logic                  DUT_error;
   logic [3:0]            fu_valid;
   logic [3:0]            fu_ready;
   logic [3:0][TAG_W-1:0] fu_tag;
   logic [3:0][31:0]      fu_data;
   logic [3:0][ROB_W-1:0] fu_rob;
   logic                  b0_valid, b1_valid;
   logic [TAG_W-1:0]      b0_tag, b1_tag;
   logic [31:0]           b0_data, b1_data;
   logic [ROB_W-1:0]      b0_rob, b1_rob;

   int checks = 0;
   int errors = 0;

   complete_bus_arbiter #(.TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
      .CLK                              (CLK),
      .RST                              (RST),
      .DUT_error                        (DUT_error),
      .fu_valid                         (fu_valid),
      .fu_ready                         (fu_ready),
      .fu_dest_phys_reg_tag             (fu_tag),
      .fu_data                          (fu_data),
      .fu_rob_index                     (fu_rob),
      .complete_bus_0_valid             (b0_valid),
      .complete_bus_0_dest_phys_reg_tag (b0_tag),
      .complete_bus_0_data              (b0_data),
      .complete_bus_0_rob_index         (b0_rob),
      .complete_bus_1_valid             (b1_valid),
      .complete_bus_1_dest_phys_reg_tag (b1_tag),
      .complete_bus_1_data              (b1_data),
      .complete_bus_1_rob_index         (b1_rob)
   );

   always #5 CLK = ~CLK;

   task automatic clear_inputs();
      fu_valid = '0;
      fu_tag   = '0;
      fu_data  = '0;
      fu_rob   = '0;
   endtask

   task automatic reset_dut();
      @(negedge CLK);
      RST = 1'b1;
      clear_inputs();
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      clear_inputs();
      @(negedge CLK);
      checks++; if (b0_valid !== 1'b0) begin errors++; $display("FAIL reset_b0_valid got %0b want 0", b0_valid); end
      checks++; if (b1_valid !== 1'b0) begin errors++; $display("FAIL reset_b1_valid got %0b want 0", b1_valid); end
      checks++; if (b0_tag !== '0 || b0_data !== '0 || b0_rob !== '0) begin errors++; $display("FAIL reset_b0_fields got %0d/%0h/%0d want 0/0/0", b0_tag, b0_data, b0_rob); end
      checks++; if (b1_tag !== '0 || b1_data !== '0 || b1_rob !== '0) begin errors++; $display("FAIL reset_b1_fields got %0d/%0h/%0d want 0/0/0", b1_tag, b1_data, b1_rob); end
      checks++; if (DUT_error !== 1'b0) begin errors++; $display("FAIL reset_error got %0b want 0", DUT_error); end
      checks++; if (fu_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready got %b want 1111", fu_ready); end
      RST = 1'b0;
   endtask

   task automatic test_single();
      reset_dut();
      fu_valid[2] = 1'b1;
      fu_tag[2]   = TAG_W'(5);
      fu_data[2]  = 32'hAA;
      fu_rob[2]   = ROB_W'(3);
      for (int e = 1; e <= 3; e++) begin
         @(negedge CLK);
         fu_valid = '0;
         checks++; if (b0_valid !== 1'(e == LAT)) begin errors++; $display("FAIL single_b0_valid edge %0d got %0b want %0b", e, b0_valid, e == LAT); end
         checks++; if (b1_valid !== 1'b0) begin errors++; $display("FAIL single_b1_valid edge %0d got %0b want 0", e, b1_valid); end
         if (e == LAT) begin
            checks++; if (b0_tag !== TAG_W'(5) || b0_data !== 32'hAA || b0_rob !== ROB_W'(3)) begin
               errors++; $display("FAIL single_b0_fields got %0d/%0h/%0d want 5/aa/3", b0_tag, b0_data, b0_rob); end
         end
      end
      checks++; if (b0_tag !== TAG_W'(5) || b0_data !== 32'hAA) begin errors++; $display("FAIL single_hold got %0d/%0h want 5/aa", b0_tag, b0_data); end
   endtask

   task automatic test_all_four();
      logic [31:0] nxt [4];
      logic [31:0] exp_d [4];
      int sent [4];
      int got [4];
      int f;
      int t0;
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         nxt[i] = 32'(i * 256); exp_d[i] = nxt[i]; sent[i] = 0; got[i] = 0;
      end
      for (int c = 0; c < 16; c++) begin
         if (c >= LAT && c <= 10) begin
            t0 = (((c - LAT) % 2) == 0) ? 10 : 12;
            checks++; if (b0_valid !== 1'b1 || b1_valid !== 1'b1) begin errors++; $display("FAIL four_valids edge %0d got %0b%0b want 11", c, b0_valid, b1_valid); end
            checks++; if (b0_tag !== TAG_W'(t0) || b1_tag !== TAG_W'(t0 + 1)) begin
               errors++; $display("FAIL four_pair edge %0d got %0d,%0d want %0d,%0d", c, b0_tag, b1_tag, t0, t0 + 1); end
            checks++; if (DUT_error !== 1'b0) begin errors++; $display("FAIL four_error edge %0d got %0b want 0", c, DUT_error); end
`ifndef COMPLETE_BUS_ARB_BYPASS_EN
            checks++; if (fu_ready !== (((c % 2) == 0) ? 4'b0011 : 4'b1100)) begin
               errors++; $display("FAIL four_ready edge %0d got %b want %b", c, fu_ready, ((c % 2) == 0) ? 4'b0011 : 4'b1100); end
`endif
         end
         if (c >= 1 && b0_valid) begin
            f = int'(b0_tag) - 10;
            checks++;
            if (f < 0 || f > 3) begin errors++; $display("FAIL four_b0_tag edge %0d got %0d want 10..13", c, b0_tag); end
            else begin
               if (b0_data !== exp_d[f]) begin errors++; $display("FAIL four_b0_order fu %0d got %0h want %0h", f, b0_data, exp_d[f]); end
               exp_d[f] = exp_d[f] + 1; got[f]++;
            end
         end
         if (c >= 1 && b1_valid) begin
            f = int'(b1_tag) - 10;
            checks++;
            if (f < 0 || f > 3) begin errors++; $display("FAIL four_b1_tag edge %0d got %0d want 10..13", c, b1_tag); end
            else begin
               if (b1_data !== exp_d[f]) begin errors++; $display("FAIL four_b1_order fu %0d got %0h want %0h", f, b1_data, exp_d[f]); end
               exp_d[f] = exp_d[f] + 1; got[f]++;
            end
         end
         if (c < 10) begin
            for (int i = 0; i < 4; i++) begin
               fu_valid[i] = 1'b1;
               fu_tag[i]   = TAG_W'(10 + i);
               fu_data[i]  = nxt[i];
               fu_rob[i]   = ROB_W'(nxt[i]);
               if (fu_ready[i]) begin nxt[i] = nxt[i] + 1; sent[i]++; end
            end
         end else begin
            fu_valid = '0;
         end
         @(negedge CLK);
      end
      for (int i = 0; i < 4; i++) begin
         checks++; if (got[i] != sent[i]) begin errors++; $display("FAIL four_count fu %0d got %0d want %0d", i, got[i], sent[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int idx = 0;
      int seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (c >= 1) begin
            checks++; if (b1_valid !== 1'b0) begin errors++; $display("FAIL b2b_b1_valid cycle %0d got %0b want 0", c, b1_valid); end
            if (b0_valid) begin
               checks++; if (b0_tag !== TAG_W'(20 + seen) || b0_data !== 32'(32'h100 + seen)) begin
                  errors++; $display("FAIL b2b_order got %0d/%0h want %0d/%0h", b0_tag, b0_data, 20 + seen, 32'h100 + seen); end
               seen++;
            end
         end
         if (idx < 3) begin
            fu_valid[1] = 1'b1;
            fu_tag[1]   = TAG_W'(20 + idx);
            fu_data[1]  = 32'(32'h100 + idx);
            fu_rob[1]   = ROB_W'(idx);
            if (fu_ready[1]) idx++;
         end else begin
            fu_valid[1] = 1'b0;
         end
         @(negedge CLK);
      end
      checks++; if (seen != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", seen); end
   endtask

   task automatic test_error();
      fu_valid    = '0;
      fu_valid[3] = 1'b1;
      fu_tag[3]   = '0;
      fu_data[3]  = 32'h1;
      for (int e = 1; e <= 4; e++) begin
         @(negedge CLK);
         fu_valid = '0;
         checks++; if (DUT_error !== 1'(e == LAT)) begin errors++; $display("FAIL err_tag0 edge %0d got %0b want %0b", e, DUT_error, e == LAT); end
      end
      fu_valid[0] = 1'b1; fu_tag[0] = TAG_W'(7); fu_data[0] = 32'h70;
      fu_valid[2] = 1'b1; fu_tag[2] = TAG_W'(7); fu_data[2] = 32'h72;
      for (int e = 1; e <= 3; e++) begin
         @(negedge CLK);
         fu_valid = '0;
         checks++; if (DUT_error !== 1'(e == LAT)) begin errors++; $display("FAIL err_equal edge %0d got %0b want %0b", e, DUT_error, e == LAT); end
         if (e == LAT) begin
            checks++; if (b0_valid !== 1'b1 || b1_valid !== 1'b1) begin errors++; $display("FAIL err_equal_valids got %0b%0b want 11", b0_valid, b1_valid); end
         end
      end
   endtask

   task automatic test_reset_mid();
      reset_dut();
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 4; i++) begin
            fu_valid[i] = 1'b1;
            fu_tag[i]   = TAG_W'(10 + i);
            fu_data[i]  = 32'(c);
         end
         @(negedge CLK);
      end
      checks++; if (b0_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %0b want 1", b0_valid); end
      fu_valid = '0;
      RST = 1'b1;
      #1;
      checks++; if (b0_valid !== 1'b0 || b1_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valids got %0b%0b want 00", b0_valid, b1_valid); end
      checks++; if (fu_ready !== 4'b1111) begin errors++; $display("FAIL rmid_ready got %b want 1111", fu_ready); end
      fu_valid = 4'b1111;
      for (int i = 0; i < 4; i++) fu_tag[i] = TAG_W'(30 + i);
      @(negedge CLK);
      checks++; if (fu_ready !== 4'b1111 || b0_valid !== 1'b0) begin errors++; $display("FAIL rmid_hold got ready %b valid %0b want 1111/0", fu_ready, b0_valid); end
      fu_valid = '0;
      RST = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge CLK);
         checks++; if (b0_valid !== 1'b0 || b1_valid !== 1'b0) begin errors++; $display("FAIL rmid_after cycle %0d got %0b%0b want 00", c, b0_valid, b1_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_back_to_back();
      test_error();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
